xbar_port_arbiter: RTL and testbench
====================================

Name: xbar_port_arbiter

Overview:
- Per-master-port packet arbiter for the streaming crossbar; one instance per output port.
- Picks one of S_DATA_COUNT source streams requesting this port and grants it with round-robin priority.
- Holds the grant for the whole packet, up to and including the beat with last.
- Drives the output-mux select, output id, output valid and per-source ready for that port.

Parameters:
- S_DATA_COUNT, 5, number of source (slave) streams competing for this port; need not be a power of 2.
- T_ID___WIDTH, $clog2(S_DATA_COUNT), width of the granted-source index.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-high: asserted when 1, despite the name.
- req_i  in  S_DATA_COUNT  per source: s_valid AND (s_dest == this port), formed outside the block.
- last_i  in  S_DATA_COUNT  per source: s_last.
- ready_i  in  1  downstream m_ready of this port.
- grant_o  out  S_DATA_COUNT  one-hot mux select; all zero when nothing is granted.
- grant_id_o  out  T_ID___WIDTH  index of the granted source; this is m_id.
- grant_valid_o  out  1  m_valid, equal to req_i[granted source].
- grant_last_o  out  1  m_last, equal to last_i[granted source] AND grant_valid_o.
- ready_o  out  S_DATA_COUNT  per-source ready contribution: grant_o AND ready_i.
- busy_o  out  1  1 while a packet is locked mid-transfer (LOCKED state).

Behaviour:
- State: FSM {UNLOCKED, LOCKED}, owner register (T_ID___WIDTH), rr pointer ptr (T_ID___WIDTH).
- Reset values: state UNLOCKED, owner 0, ptr 0, busy_o 0.
- Outputs are combinational from state and inputs. With req_i = 0 after reset: grant_o 0, grant_id_o 0, grant_valid_o 0, grant_last_o 0, ready_o 0.
- Zero latency: a beat presented while UNLOCKED is granted and transferred in the same cycle. The first beat needs no setup cycle.
- UNLOCKED grant selection:
  - Winner is the first set req_i bit scanning ptr, ptr+1, … S_DATA_COUNT-1, 0, … ptr-1. Index arithmetic wraps modulo S_DATA_COUNT, not 2^width.
  - No req set: grant_o 0, grant_valid_o 0, grant_id_o holds 0.
- LOCKED grant: grant_o = one-hot(owner), grant_id_o = owner, independent of other requesters.
  - If req_i[owner] drops mid-packet: grant_valid_o = 0 and the lock is kept. There is no timeout and no pre-emption.
- Transfer condition: xfer = grant_valid_o AND ready_i.
- Next-state rules, registered:
  - xfer with grant_last_o = 1: state UNLOCKED; ptr = (granted id + 1) mod S_DATA_COUNT, so id S_DATA_COUNT-1 wraps to 0.
  - xfer with grant_last_o = 0: state LOCKED; owner = granted id; ptr unchanged.
  - No xfer: state, owner and ptr all hold. An UNLOCKED tentative grant that stalls on ready_i = 0 does not lock, and may change next cycle if a higher-priority request appears.
- Single-beat packet (last on the first beat): granted and released in one cycle; never enters LOCKED.
- Back-to-back: after a last beat the next packet can be granted in the very next cycle, with zero bubble, using the new ptr.
- Reset asserted mid-packet: lock dropped, ptr returns to 0 on that edge, and in-flight packet state is discarded.
- Requests that never hit this port are ignored. Sources not granted see ready_o = 0.

Decomposition:
- Shared package/include holds:
  - State encodings (XBAR_ARB_UNLOCKED = 1'b0, XBAR_ARB_LOCKED = 1'b1).
  - A wrap-increment function (idx+1 mod S_DATA_COUNT), also reused by the crossbar top.
- One sub-module: xbar_rr_pick. Combinational rotating-priority encoder with inputs req, ptr and outputs valid, one-hot, idx. It is verified standalone for all ptr values and non-power-of-2 S.

Test Plan:
- Reset, then req_i = 5'b00000 → grant_o 0, grant_valid_o 0, busy_o 0, grant_id_o 0.
- req_i = 5'b11111, one-beat packets (last on each requester), ready_i = 1 for 5 cycles → grant_id_o sequence 0, 1, 2, 3, 4, then wraps to 0. grant_valid_o = 1 every cycle.
- req_i = 5'b00110; source 1 sends 3 beats (last on the third) while source 2 keeps requesting → grant_id_o = 1 for 3 cycles, busy_o = 1 after beat 1 and beat 2, then grant_id_o = 2 with no bubble.
- Locked on source 3 after beat 1; req_i[3] drops for 2 cycles while source 0 requests → grant_valid_o 0, grant_id_o stays 3, ready_o[0] = 0. On resume, source 3 finishes its packet.
- ready_i = 0 while UNLOCKED with req_i = 5'b01000, then req_i = 5'b01001 with ptr = 0 → grant switches to id 0. No lock is taken before the first xfer.
- Mid-packet rst_n = 1 for one cycle while locked on source 4 → busy_o 0 and ptr 0 afterwards; req_i = 5'b10001 then grants id 0.

Source files
------------

// File: rtl/xbar_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xbar_port_arbiter_pkg
// Purpose  : Shared state encodings and index helpers for the crossbar
//            per-port arbiter and the crossbar top.
// Revision : 1.0 - initial release
// ============================================================================
package xbar_port_arbiter_pkg;

    localparam logic [0:0] XBAR_ARB_UNLOCKED = 1'b0;
    localparam logic [0:0] XBAR_ARB_LOCKED   = 1'b1;

    typedef enum logic [0:0] {
        ST_UNLOCKED = XBAR_ARB_UNLOCKED,
        ST_LOCKED   = XBAR_ARB_LOCKED
    } xbar_arb_state_t;

    // Wraps at the source count, not at a power of two.
    function automatic logic [31:0] xbar_wrap_inc(input logic [31:0] idx,
                                                  input logic [31:0] count);
        logic [31:0] nxt;
        nxt = idx + 32'd1;
        return (nxt >= count) ? 32'd0 : nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xbar_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : xbar_rr_pick
// Purpose  : Combinational rotating-priority encoder; first set request at or
//            after ptr, wrapping modulo S_DATA_COUNT.
// Revision : 1.0 - initial release
// ============================================================================
module xbar_rr_pick
    import xbar_port_arbiter_pkg::*;
#(
    parameter int S_DATA_COUNT = 5,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
    input  logic [S_DATA_COUNT-1:0] req,
    input  logic [T_ID___WIDTH-1:0] ptr,
    output logic                    valid,
    output logic [S_DATA_COUNT-1:0] onehot,
    output logic [T_ID___WIDTH-1:0] idx
);

    logic                    w_valid;
    logic [S_DATA_COUNT-1:0] w_onehot;
    logic [T_ID___WIDTH-1:0] w_idx;
    logic [31:0]             w_cand;

    always_comb begin
        w_valid  = 1'b0;
        w_onehot = '0;
        w_idx    = '0;
        w_cand   = 32'(ptr);
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            if (!w_valid && req[w_cand]) begin
                w_valid = 1'b1;
                w_idx   = T_ID___WIDTH'(w_cand);
            end
            w_cand = xbar_wrap_inc(w_cand, 32'(S_DATA_COUNT));
        end
        if (w_valid) begin
            w_onehot[w_idx] = 1'b1;
        end
    end

    assign valid  = w_valid;
    assign onehot = w_onehot;
    assign idx    = w_idx;

endmodule
`default_nettype wire

// File: rtl/xbar_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xbar_port_arbiter
// Purpose  : Per-output-port packet arbiter: round-robin pick, grant held
//            from first beat through the last beat, zero-latency grant.
// Revision : 1.0 - initial release
// ============================================================================
module xbar_port_arbiter
    import xbar_port_arbiter_pkg::*;
#(
    parameter int S_DATA_COUNT = 5,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [S_DATA_COUNT-1:0] req_i,
    input  logic [S_DATA_COUNT-1:0] last_i,
    input  logic                    ready_i,
    output logic [S_DATA_COUNT-1:0] grant_o,
    output logic [T_ID___WIDTH-1:0] grant_id_o,
    output logic                    grant_valid_o,
    output logic                    grant_last_o,
    output logic [S_DATA_COUNT-1:0] ready_o,
    output logic                    busy_o
);

    xbar_arb_state_t         r_state;
    xbar_arb_state_t         w_state_nxt;
    logic [T_ID___WIDTH-1:0] r_owner;
    logic [T_ID___WIDTH-1:0] w_owner_nxt;
    logic [T_ID___WIDTH-1:0] r_ptr;
    logic [T_ID___WIDTH-1:0] w_ptr_nxt;

    logic                    w_pick_valid;
    logic [S_DATA_COUNT-1:0] w_pick_onehot;
    logic [T_ID___WIDTH-1:0] w_pick_idx;

    logic [S_DATA_COUNT-1:0] w_grant;
    logic [T_ID___WIDTH-1:0] w_grant_id;
    logic                    w_grant_valid;
    logic                    w_grant_last;
    logic                    w_xfer;

    xbar_rr_pick #(
        .S_DATA_COUNT (S_DATA_COUNT),
        .T_ID___WIDTH (T_ID___WIDTH)
    ) u_rr_pick (
        .req    (req_i),
        .ptr    (r_ptr),
        .valid  (w_pick_valid),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= ST_UNLOCKED;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_grant       = '0;
        w_grant_id    = '0;
        w_grant_valid = 1'b0;
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;

        // While locked the owner keeps the mux even if it stops requesting.
        if (r_state == ST_LOCKED) begin
            w_grant[r_owner] = 1'b1;
            w_grant_id       = r_owner;
            w_grant_valid    = req_i[r_owner];
        end else begin
            w_grant       = w_pick_onehot;
            w_grant_id    = w_pick_idx;
            w_grant_valid = w_pick_valid;
        end

        w_grant_last = last_i[w_grant_id] & w_grant_valid;
        w_xfer       = w_grant_valid & ready_i;

        if (w_xfer) begin
            if (w_grant_last) begin
                w_state_nxt = ST_UNLOCKED;
                w_ptr_nxt   = T_ID___WIDTH'(xbar_wrap_inc(32'(w_grant_id), 32'(S_DATA_COUNT)));
            end else begin
                w_state_nxt = ST_LOCKED;
                w_owner_nxt = w_grant_id;
            end
        end
    end

    assign grant_o       = w_grant;
    assign grant_id_o    = w_grant_id;
    assign grant_valid_o = w_grant_valid;
    assign grant_last_o  = w_grant_last;
    assign ready_o       = w_grant & {S_DATA_COUNT{ready_i}};
    assign busy_o        = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_xbar_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_xbar_port_arbiter
// Purpose  : Self-checking bench for xbar_port_arbiter: directed scenarios and
//            randomized traffic against a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbar_port_arbiter;

    localparam int S = 5;
    localparam int W = $clog2(S);

    logic         clk = 1'b0;
    logic         rst_n;
    logic [S-1:0] req_i;
    logic [S-1:0] last_i;
    logic         ready_i;
    logic [S-1:0] grant_o;
    logic [W-1:0] grant_id_o;
    logic         grant_valid_o;
    logic         grant_last_o;
    logic [S-1:0] ready_o;
    logic         busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: packet-level view of ownership and priority.
    bit           m_locked;
    int           m_owner;
    int           m_ptr;
    int           e_id;
    bit           e_valid;
    bit           e_last;
    logic [S-1:0] e_grant;
    logic [S-1:0] e_ready;

    xbar_port_arbiter #(
        .S_DATA_COUNT (S),
        .T_ID___WIDTH (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .last_i        (last_i),
        .ready_i       (ready_i),
        .grant_o       (grant_o),
        .grant_id_o    (grant_id_o),
        .grant_valid_o (grant_valid_o),
        .grant_last_o  (grant_last_o),
        .ready_o       (ready_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic model_eval();
        e_id    = 0;
        e_valid = 0;
        e_grant = '0;
        if (m_locked) begin
            e_id          = m_owner;
            e_valid       = req_i[m_owner];
            e_grant[e_id] = 1'b1;
        end else begin
            for (int k = 0; k < S; k++) begin
                if (!e_valid && req_i[(m_ptr + k) % S]) begin
                    e_valid = 1;
                    e_id    = (m_ptr + k) % S;
                end
            end
            if (e_valid) e_grant[e_id] = 1'b1;
        end
        e_last  = e_valid && last_i[e_id];
        e_ready = ready_i ? e_grant : '0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst_n) begin
            m_locked = 0;
            m_owner  = 0;
            m_ptr    = 0;
        end else if (e_valid && ready_i) begin
            if (e_last) begin
                m_locked = 0;
                m_ptr    = (e_id + 1) % S;
            end else begin
                m_locked = 1;
                m_owner  = e_id;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1; req_i = '0; last_i = '0; ready_i = 0;
        tick(); tick();
        rst_n = 0;
        #2;
        n_checks++;
        if (grant_o !== '0 || grant_valid_o !== 1'b0 || busy_o !== 1'b0 ||
            grant_id_o !== '0 || ready_o !== '0 || grant_last_o !== 1'b0)
            $display("FAIL reset: grant=%b valid=%b busy=%b id=%0d ready=%b last=%b, want all 0",
                     grant_o, grant_valid_o, busy_o, grant_id_o, ready_o, grant_last_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_rr_single_beat();
        req_i = 5'b11111; last_i = 5'b11111; ready_i = 1;
        for (int c = 0; c < 6; c++) begin
            #2;
            n_checks++;
            if (grant_id_o !== W'(c % S) || grant_valid_o !== 1'b1 || busy_o !== 1'b0 ||
                grant_o !== S'(1 << (c % S)))
                $display("FAIL rr_single cycle%0d: id=%0d valid=%b busy=%b grant=%b, want id=%0d valid=1 busy=0",
                         c, grant_id_o, grant_valid_o, busy_o, grant_o, c % S);
            else n_pass++;
            tick();
        end
        req_i = '0; last_i = '0;
        tick();
    endtask

    task automatic test_multibeat();
        // ptr is 1 here after six single-beat grants from 0.
        logic [S-1:0] lasts [4];
        bit           busys [4];
        int           ids   [4];
        lasts = '{5'b00000, 5'b00000, 5'b00010, 5'b00000};
        busys = '{0, 1, 1, 0};
        ids   = '{1, 1, 1, 2};
        req_i = 5'b00110; ready_i = 1;
        for (int c = 0; c < 4; c++) begin
            last_i = lasts[c];
            if (c == 3) req_i = 5'b00100;
            #2;
            n_checks++;
            if (grant_id_o !== W'(ids[c]) || busy_o !== busys[c] || grant_valid_o !== 1'b1 ||
                grant_last_o !== (c == 2))
                $display("FAIL multibeat beat%0d: id=%0d busy=%b valid=%b last=%b, want id=%0d busy=%0d valid=1 last=%0d",
                         c, grant_id_o, busy_o, grant_valid_o, grant_last_o, ids[c], busys[c], c == 2);
            else n_pass++;
            tick();
        end
        last_i = 5'b00100;
        tick();
        req_i = '0; last_i = '0;
        tick();
    endtask

    task automatic test_owner_drop();
        // ptr is 3 here.
        req_i = 5'b01000; last_i = '0; ready_i = 1;
        tick();
        req_i = 5'b00001;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_checks++;
            if (grant_valid_o !== 1'b0 || grant_id_o !== W'(3) || ready_o[0] !== 1'b0 ||
                busy_o !== 1'b1 || grant_o !== 5'b01000)
                $display("FAIL owner_drop cycle%0d: valid=%b id=%0d ready=%b busy=%b grant=%b, want valid=0 id=3 ready[0]=0 busy=1",
                         c, grant_valid_o, grant_id_o, ready_o, busy_o, grant_o);
            else n_pass++;
            tick();
        end
        req_i = 5'b01001; last_i = 5'b01000;
        #2;
        n_checks++;
        if (grant_id_o !== W'(3) || grant_valid_o !== 1'b1 || grant_last_o !== 1'b1 ||
            ready_o !== 5'b01000)
            $display("FAIL owner_resume: id=%0d valid=%b last=%b ready=%b, want id=3 valid=1 last=1 ready=01000",
                     grant_id_o, grant_valid_o, grant_last_o, ready_o);
        else n_pass++;
        tick();
        req_i = '0; last_i = '0;
        tick();
    endtask

    task automatic test_stall_switch();
        // Single beat from source 4 brings ptr back to 0.
        req_i = 5'b10000; last_i = 5'b10000; ready_i = 1;
        tick();
        req_i = 5'b01000; last_i = '0; ready_i = 0;
        #2;
        n_checks++;
        if (grant_id_o !== W'(3) || grant_valid_o !== 1'b1 || ready_o !== '0)
            $display("FAIL stall_tentative: id=%0d valid=%b ready=%b, want id=3 valid=1 ready=0",
                     grant_id_o, grant_valid_o, ready_o);
        else n_pass++;
        tick();
        req_i = 5'b01001;
        #2;
        n_checks++;
        if (grant_id_o !== W'(0) || busy_o !== 1'b0 || grant_o !== 5'b00001)
            $display("FAIL stall_switch: id=%0d busy=%b grant=%b, want id=0 busy=0 grant=00001",
                     grant_id_o, busy_o, grant_o);
        else n_pass++;
        ready_i = 1; last_i = 5'b00001;
        tick();
        req_i = '0; last_i = '0;
        tick();
    endtask

    task automatic test_mid_reset();
        // ptr is 1; lock on source 4 with a multi-beat packet.
        req_i = 5'b10000; last_i = '0; ready_i = 1;
        tick();
        #2;
        n_checks++;
        if (busy_o !== 1'b1 || grant_id_o !== W'(4))
            $display("FAIL mid_reset_locked: busy=%b id=%0d, want busy=1 id=4", busy_o, grant_id_o);
        else n_pass++;
        rst_n = 1;
        tick();
        rst_n = 0; req_i = 5'b10001; ready_i = 0;
        #2;
        n_checks++;
        if (busy_o !== 1'b0 || grant_id_o !== W'(0) || grant_o !== 5'b00001)
            $display("FAIL mid_reset_after: busy=%b id=%0d grant=%b, want busy=0 id=0 grant=00001",
                     busy_o, grant_id_o, grant_o);
        else n_pass++;
        req_i = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n   = ($urandom_range(0, 59) == 0);
            req_i   = S'($urandom);
            last_i  = S'($urandom) & S'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            model_eval();
            #2;
            n_checks++;
            if (grant_o !== e_grant || grant_id_o !== W'(e_id) || grant_valid_o !== e_valid ||
                grant_last_o !== e_last || ready_o !== e_ready || busy_o !== m_locked)
                $display("FAIL random cycle%0d: grant=%b id=%0d valid=%b last=%b ready=%b busy=%b, want grant=%b id=%0d valid=%b last=%b ready=%b busy=%b",
                         c, grant_o, grant_id_o, grant_valid_o, grant_last_o, ready_o, busy_o,
                         e_grant, e_id, e_valid, e_last, e_ready, m_locked);
            else n_pass++;
            tick();
        end
        rst_n = 0; req_i = '0;
    endtask

    initial begin
        m_locked = 0;
        m_owner  = 0;
        m_ptr    = 0;
        rst_n    = 1;
        req_i    = '0;
        last_i   = '0;
        ready_i  = 0;
        #1;
        test_reset();
        test_rr_single_beat();
        test_multibeat();
        test_owner_drop();
        test_stall_switch();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
